// File: rtl/audio_sample_streamer_if.sv
`default_nettype none
// ============================================================================
// Module  : audio_sample_streamer_if
// Brief   : Control, ROM and sample-output bundle for audio_sample_streamer.
// Revision: 1.0 - initial release
// ============================================================================
interface audio_sample_streamer_if #(
   parameter int SAMPLE_W = 8,
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 18
);
   logic                start;
   logic                stop;
   logic                loop_en;
   logic [ADDR_W-1:0]   start_addr;
   logic [ADDR_W-1:0]   end_addr;
   logic [ADDR_W-1:0]   rom_addr;
   logic [WORD_W-1:0]   rom_data;
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_valid;
   logic                busy;
   logic                done;

   modport master (
      input  start, stop, loop_en, start_addr, end_addr, rom_data,
      output rom_addr, sample_data, sample_valid, busy, done
   );

   modport slave (
      output start, stop, loop_en, start_addr, end_addr, rom_data,
      input  rom_addr, sample_data, sample_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/audio_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module  : audio_sample_streamer
// Brief   : Streams packed PCM samples from a synchronous ROM at a fixed rate.
// Revision: 1.0 - initial release
// ============================================================================
module audio_sample_streamer #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int SAMPLE_RATE = 8000,
   parameter int SAMPLE_W    = 8,
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 18,
   parameter int ROM_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   audio_sample_streamer_if.master bus
);
   localparam int c_SPW     = WORD_W / SAMPLE_W;
   localparam int c_DIVIDER = CLK_FREQ / SAMPLE_RATE;
   localparam int c_DIV_W   = (c_DIVIDER > 1) ? $clog2(c_DIVIDER) : 1;
   localparam int c_PH_W    = (c_SPW > 1) ? $clog2(c_SPW) : 1;
   localparam int c_LAT_W   = 3;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_PLAY  = 2'd2;

   logic [1:0]          r_state, w_state_nxt;
   logic [c_DIV_W-1:0]  r_div, w_div_nxt;
   logic [c_PH_W-1:0]   r_phase, w_phase_nxt;
   logic [c_LAT_W-1:0]  r_lat_cnt, w_lat_nxt;
   logic [WORD_W-1:0]   r_word, w_word_nxt;
   logic [ADDR_W-1:0]   r_start_addr, w_start_nxt;
   logic [ADDR_W-1:0]   r_end_addr, w_end_nxt;
   logic [ADDR_W-1:0]   r_rom_addr, w_addr_nxt;
   logic [SAMPLE_W-1:0] r_sample_data, w_data_nxt;
   logic                r_sample_valid, w_valid_nxt;
   logic                r_done, w_done_nxt;

   logic w_tick, w_start_ok, w_fetch_done, w_word_end, w_last_word;
   logic [SAMPLE_W-1:0] w_lane [c_SPW];

   for (genvar i = 0; i < c_SPW; i++) begin : g_lane
      assign w_lane[i] = r_word[i*SAMPLE_W +: SAMPLE_W];
   end

   assign w_tick       = (r_div == c_DIV_W'(c_DIVIDER - 1));
   assign w_start_ok   = bus.start && (bus.start_addr <= bus.end_addr);
   assign w_fetch_done = (r_lat_cnt == c_LAT_W'(ROM_LATENCY));
   assign w_word_end   = (r_phase == c_PH_W'(c_SPW - 1));
   assign w_last_word  = (r_rom_addr == r_end_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.stop) begin
         w_state_nxt = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:  if (w_start_ok) w_state_nxt = c_FETCH;
            c_FETCH: if (w_fetch_done) w_state_nxt = c_PLAY;
            c_PLAY:  if (w_tick && w_word_end)
                        w_state_nxt = (w_last_word && !bus.loop_en) ? c_IDLE : c_FETCH;
            default: w_state_nxt = c_IDLE;
         endcase
      end
   end

   always_comb begin
      w_div_nxt   = r_div;
      w_phase_nxt = r_phase;
      w_lat_nxt   = r_lat_cnt;
      w_word_nxt  = r_word;
      w_start_nxt = r_start_addr;
      w_end_nxt   = r_end_addr;
      w_addr_nxt  = r_rom_addr;
      w_data_nxt  = r_sample_data;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      if (!bus.stop) begin
         // The rate divider free-runs through FETCH so sample spacing never stretches.
         if (r_state != c_IDLE) w_div_nxt = w_tick ? '0 : r_div + 1'b1;
         case (r_state)
            c_IDLE: if (w_start_ok) begin
               w_start_nxt = bus.start_addr;
               w_end_nxt   = bus.end_addr;
               w_addr_nxt  = bus.start_addr;
               w_div_nxt   = '0;
               w_phase_nxt = '0;
               w_lat_nxt   = '0;
            end
            c_FETCH: begin
               if (w_fetch_done) w_word_nxt = bus.rom_data;
               else              w_lat_nxt  = r_lat_cnt + 1'b1;
            end
            c_PLAY: if (w_tick) begin
               w_data_nxt  = w_lane[r_phase];
               w_valid_nxt = 1'b1;
               if (!w_word_end) begin
                  w_phase_nxt = r_phase + 1'b1;
               end else begin
                  w_phase_nxt = '0;
                  w_lat_nxt   = '0;
                  if (!w_last_word)     w_addr_nxt = r_rom_addr + 1'b1;
                  else if (bus.loop_en) w_addr_nxt = r_start_addr;
                  else                  w_done_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div          <= '0;
         r_phase        <= '0;
         r_lat_cnt      <= '0;
         r_word         <= '0;
         r_start_addr   <= '0;
         r_end_addr     <= '0;
         r_rom_addr     <= '0;
         r_sample_data  <= '0;
         r_sample_valid <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_div          <= w_div_nxt;
         r_phase        <= w_phase_nxt;
         r_lat_cnt      <= w_lat_nxt;
         r_word         <= w_word_nxt;
         r_start_addr   <= w_start_nxt;
         r_end_addr     <= w_end_nxt;
         r_rom_addr     <= w_addr_nxt;
         r_sample_data  <= w_data_nxt;
         r_sample_valid <= w_valid_nxt;
         r_done         <= w_done_nxt;
      end
   end

   assign bus.rom_addr     = r_rom_addr;
   assign bus.sample_data  = r_sample_data;
   assign bus.sample_valid = r_sample_valid;
   assign bus.done         = r_done;
   assign bus.busy         = (r_state != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_audio_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_audio_sample_streamer
// Brief   : Self-checking bench; two DUTs (ROM latency 1 and 3) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_audio_sample_streamer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   audio_sample_streamer_if #(.SAMPLE_W(8), .WORD_W(32), .ADDR_W(18)) bus1 ();
   audio_sample_streamer_if #(.SAMPLE_W(8), .WORD_W(32), .ADDR_W(18)) bus3 ();

   audio_sample_streamer #(.CLK_FREQ(40), .SAMPLE_RATE(4), .SAMPLE_W(8), .WORD_W(32),
      .ADDR_W(18), .ROM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   audio_sample_streamer #(.CLK_FREQ(40), .SAMPLE_RATE(4), .SAMPLE_W(8), .WORD_W(32),
      .ADDR_W(18), .ROM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   assign bus3.start      = bus1.start;
   assign bus3.stop       = bus1.stop;
   assign bus3.loop_en    = bus1.loop_en;
   assign bus3.start_addr = bus1.start_addr;
   assign bus3.end_addr   = bus1.end_addr;

   logic [31:0] mem [64];
   logic [17:0] a1, a2;
   always @(posedge clk) bus1.rom_data <= mem[bus1.rom_addr[5:0]];
   always @(posedge clk) begin
      a1 <= bus3.rom_addr;
      a2 <= a1;
      bus3.rom_data <= mem[a2[5:0]];
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a playback is an index into a flat sample stream; sample k
   // lands k*10 edges after the accepted start.
   logic        m_busy, e_valid, e_done;
   logic [17:0] m_a, m_b, e_addr;
   logic [7:0]  e_data;
   int          m_cyc, m_idx;

   task automatic model_step();
      int w;
      logic [31:0] word;
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (reset) begin
         m_busy = 1'b0; e_data = '0; e_addr = '0; m_cyc = 0; m_idx = 0;
      end else if (bus1.stop) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (bus1.start && bus1.start_addr <= bus1.end_addr) begin
            m_busy = 1'b1; m_a = bus1.start_addr; m_b = bus1.end_addr;
            m_cyc = 0; m_idx = 0; e_addr = bus1.start_addr;
         end
      end else begin
         m_cyc++;
         if (m_cyc % 10 == 0) begin
            w       = int'(m_a) + m_idx / 4;
            word    = mem[w[5:0]];
            e_data  = word[8*(m_idx%4) +: 8];
            e_valid = 1'b1;
            m_idx++;
            if (m_idx % 4 == 0) begin
               if (w < int'(m_b))      e_addr = 18'(w + 1);
               else if (bus1.loop_en) begin e_addr = m_a; m_idx = 0; end
               else begin e_done = 1'b1; m_busy = 1'b0; end
            end
         end
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("busy1",  bus1.busy,         m_busy);
      check("valid1", bus1.sample_valid, e_valid);
      check("data1",  bus1.sample_data,  e_data);
      check("done1",  bus1.done,         e_done);
      check("addr1",  bus1.rom_addr,     e_addr);
      check("busy3",  bus3.busy,         m_busy);
      check("valid3", bus3.sample_valid, e_valid);
      check("data3",  bus3.sample_data,  e_data);
      check("done3",  bus3.done,         e_done);
      check("addr3",  bus3.rom_addr,     e_addr);
   end

   typedef struct {
      logic [17:0] sa, ea;
      logic        lp;
      int          stop_at;
      int          n_strobe;
      logic [7:0]  last;
      int          n_done;
      logic        busy_end;
      logic [17:0] addr_end;
   } vec_t;
   vec_t tbl [6];

   task automatic pulse_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic do_start(input logic [17:0] sa, input logic [17:0] ea, input logic lp);
      @(negedge clk);
      bus1.start_addr = sa; bus1.end_addr = ea; bus1.loop_en = lp; bus1.start = 1'b1;
      @(negedge clk) bus1.start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int c1, c3, dn;
      c1 = 0; c3 = 0; dn = 0;
      pulse_reset();
      do_start(v.sa, v.ea, v.lp);
      for (int k = 1; k <= 95; k++) begin
         @(negedge clk);
         if (bus1.sample_valid) c1++;
         if (bus3.sample_valid) c3++;
         if (bus1.done) dn++;
         bus1.stop = (v.stop_at == k + 1);
      end
      bus1.stop = 1'b0;
      check($sformatf("vec%0d_strobes1", idx), c1, v.n_strobe);
      check($sformatf("vec%0d_strobes3", idx), c3, v.n_strobe);
      check($sformatf("vec%0d_last", idx), bus1.sample_data, v.last);
      check($sformatf("vec%0d_done", idx), dn, v.n_done);
      check($sformatf("vec%0d_busy", idx), bus1.busy, v.busy_end);
      check($sformatf("vec%0d_addr", idx), bus1.rom_addr, v.addr_end);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[5] = 32'h44332211;
      mem[6] = 32'h88776655;
      bus1.start = 1'b0; bus1.stop = 1'b0; bus1.loop_en = 1'b0;
      bus1.start_addr = '0; bus1.end_addr = '0;

      tbl[0] = '{18'd5, 18'd6, 1'b0, 0,  8, 8'h88, 1, 1'b0, 18'd6};
      tbl[1] = '{18'd5, 18'd6, 1'b1, 0,  9, 8'h11, 0, 1'b1, 18'd5};
      tbl[2] = '{18'd5, 18'd6, 1'b0, 35, 3, 8'h33, 0, 1'b0, 18'd5};
      tbl[3] = '{18'd7, 18'd6, 1'b0, 0,  0, 8'h00, 0, 1'b0, 18'd0};
      tbl[4] = '{18'd6, 18'd6, 1'b0, 0,  4, 8'h88, 1, 1'b0, 18'd6};
      tbl[5] = '{18'd6, 18'd6, 1'b1, 0,  9, 8'h55, 0, 1'b1, 18'd6};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

      // Asynchronous reset in the middle of playback, then a clean replay.
      pulse_reset();
      do_start(18'd5, 18'd6, 1'b0);
      repeat (24) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_busy",  bus1.busy,         1'b0);
      check("rst_valid", bus1.sample_valid, 1'b0);
      check("rst_data",  bus1.sample_data,  8'h00);
      check("rst_addr",  bus1.rom_addr,     18'd0);
      check("rst_done",  bus1.done,         1'b0);
      @(negedge clk) reset = 1'b0;
      do_start(18'd5, 18'd6, 1'b0);
      repeat (10) @(negedge clk);
      check("replay_valid", bus1.sample_valid, 1'b1);
      check("replay_data",  bus1.sample_data,  8'h11);

      // start and stop together while idle must not begin playback.
      pulse_reset();
      @(negedge clk);
      bus1.start_addr = 18'd5; bus1.end_addr = 18'd6;
      bus1.start = 1'b1; bus1.stop = 1'b1;
      @(negedge clk) begin bus1.start = 1'b0; bus1.stop = 1'b0; end
      check("start_stop_busy", bus1.busy, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 699) == 0);
         bus1.start = ($urandom_range(0, 19) == 0);
         bus1.stop  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 49) == 0) bus1.loop_en = ~bus1.loop_en;
         if (bus1.start) begin
            bus1.start_addr = 18'($urandom_range(0, 15));
            bus1.end_addr   = 18'($urandom_range(0, 20));
         end
      end
      @(negedge clk) begin reset = 1'b0; bus1.start = 1'b0; bus1.stop = 1'b0; end
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
`default_nettype wire
